// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory line arbiter.
// Covers FSM states, owner ids and word size.
package mem_arb_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
// Holds the last-grant flop; a tie goes to the side not served last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_own,
  output logic       gnt,
  output logic       gnt_own
);

  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= OWN_I;
    end else if (upd) begin
      last <= upd_own;
    end
  end

  assign gnt     = |req;
  assign gnt_own = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one main memory between I-cache refill and D-cache refill/writeback.
// Whole lines move one word at a time; transfers are never interrupted.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_LATENCY   = 2,
  parameter int ADDR_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     i_rvalid,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_rvalid,
  output logic                     d_done,
  output logic [LINE_ADDR_LEN-1:0] word_idx,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     owner,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int OFS_W = $clog2(WORD_BYTES);
  localparam int LO_W  = LINE_ADDR_LEN + OFS_W;
  localparam int LN_W  = ADDR_W - LO_W;
  localparam logic [LINE_ADDR_LEN-1:0] LAST = '1;
  localparam logic [3:0] LAT_INI = 4'(MEM_LATENCY - 1);

  logic [1:0]               state;
  logic [LN_W-1:0]          line_q;
  logic                     we_q;
  logic                     own_q;
  logic [LINE_ADDR_LEN-1:0] cnt;
  logic [LINE_ADDR_LEN-1:0] rd_idx;
  logic [3:0]               lat;
  logic                     rv;
  logic                     gnt;
  logic                     gnt_own;
  logic                     issue;
  logic                     fin;
  logic                     unused;

  assign unused = ^{i_addr[LO_W-1:0], d_addr[LO_W-1:0]};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req, i_req}),
    .upd     (fin),
    .upd_own (own_q),
    .gnt     (gnt),
    .gnt_own (gnt_own)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      line_q <= '0;
      we_q   <= 1'b0;
      own_q  <= OWN_I;
      cnt    <= '0;
      rd_idx <= '0;
      lat    <= '0;
      rv     <= 1'b0;
      rdata  <= '0;
    end else begin
      rv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt) begin
            line_q <= gnt_own ? d_addr[ADDR_W-1:LO_W]
                              : i_addr[ADDR_W-1:LO_W];
            we_q   <= gnt_own & d_we;
            own_q  <= gnt_own;
            cnt    <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          lat   <= LAT_INI;
          state <= WAIT;
        end
        WAIT: begin
          if (lat == 4'd0) begin
            if (!we_q) begin
              rdata  <= mem_rdata;
              rv     <= 1'b1;
              rd_idx <= cnt;
            end
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ISSUE;
            end
          end else begin
            lat <= lat - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign issue = (state == ISSUE);
  assign fin   = (state == DONE);

  assign busy      = (state != IDLE);
  assign owner     = own_q;
  assign mem_en    = issue;
  assign mem_wr    = issue & we_q;
  assign mem_addr  = issue ? {line_q, cnt, {OFS_W{1'b0}}} : '0;
  assign mem_wdata = (issue & we_q) ? d_wdata : '0;

  // A read word's index trails the counter by one word period.
  assign word_idx = rv ? rd_idx : cnt;

  assign i_rvalid = rv  & (own_q == OWN_I);
  assign d_rvalid = rv  & (own_q == OWN_D);
  assign i_done   = fin & (own_q == OWN_I);
  assign d_done   = fin & (own_q == OWN_D);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: three builds (latency 2, 1, 15)
// with delayed-return memory models and queue scoreboards.
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] i_req, d_req, d_we;
  logic [2:0] i_rvalid, i_done, d_rvalid, d_done;
  logic [2:0] busy, owner, mem_en, mem_wr;
  logic [2:0][31:0] i_addr, d_addr, d_wdata, rdata;
  logic [2:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0][2:0] word_idx;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] wdf(input logic [31:0] a,
                                      input logic [2:0] i);
    return {16'hC0DE, a[7:0], 5'd0, i};
  endfunction

  function automatic int latof(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  function automatic logic [106:0] outs(input int g);
    return {i_rvalid[g], i_done[g], d_rvalid[g], d_done[g],
            busy[g], owner[g], mem_en[g], mem_wr[g], word_idx[g],
            rdata[g], mem_addr[g], mem_wdata[g]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [31:0] ap[16];
    logic        vp[16];

    assign d_wdata[g]   = wdf(d_addr[g], word_idx[g]);
    assign mem_rdata[g] = vp[L-1] ? memf(ap[L-1]) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
      for (int i = 15; i > 0; i--) begin
        ap[i] <= ap[i-1];
        vp[i] <= vp[i-1];
      end
      ap[0] <= mem_addr[g];
      vp[0] <= mem_en[g] & ~mem_wr[g];
    end

    mem_line_arbiter #(
      .LINE_ADDR_LEN (3),
      .MEM_LATENCY   (L),
      .ADDR_W        (32)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_rvalid  (i_rvalid[g]),
      .i_done    (i_done[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_done    (d_done[g]),
      .word_idx  (word_idx[g]),
      .rdata     (rdata[g]),
      .busy      (busy[g]),
      .owner     (owner[g]),
      .mem_en    (mem_en[g]),
      .mem_wr    (mem_wr[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  task automatic apply_reset();
    rst    = 1'b1;
    i_req  = '0;
    d_req  = '0;
    d_we   = '0;
    i_addr = '0;
    d_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    i_req  = '0;
    d_req  = '0;
    d_we   = '0;
    i_addr = '0;
    d_addr = '0;
    #3;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (outs(g) !== '0) begin
        failures++;
        $display("FAIL reset_hold g=%0d got %h want 0", g, outs(g));
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (outs(g) !== '0) begin
        failures++;
        $display("FAIL reset_idle g=%0d got %h want 0", g, outs(g));
      end
    end
  endtask

  task automatic test_i_refill(input int g, input logic [31:0] addr);
    logic [31:0] qa[$];
    logic [34:0] qr[$];
    logic [31:0] base, ea;
    logic [34:0] er;
    int lat, n, n0, pen, nd, nrv, nen;
    bit seen_d;
    lat = latof(g);
    n = 0; n0 = -1; pen = -1; nd = -1; nrv = 0; nen = 0;
    seen_d = 1'b0;
    base = addr & ~32'h1F;
    for (int k = 0; k < N; k++) begin
      qa.push_back(base + 32'(4 * k));
      qr.push_back({3'(k), memf(base + 32'(4 * k))});
    end
    @(negedge clk);
    i_req[g]  = 1'b1;
    i_addr[g] = addr;
    while (nd < 0 && n < 4 * N * (lat + 1) + 20) begin
      @(negedge clk);
      n++;
      if (busy[g] && n0 < 0) n0 = n;
      if (mem_en[g]) begin
        ea = (qa.size() > 0) ? qa.pop_front() : 32'hFFFF_FFFF;
        nen++;
        checks++;
        if ({mem_wr[g], mem_addr[g]} !== {1'b0, ea}) begin
          failures++;
          $display("FAIL i_issue g=%0d got wr=%b a=%h want wr=0 a=%h",
                   g, mem_wr[g], mem_addr[g], ea);
        end
        if (pen >= 0) begin
          checks++;
          if (n - pen != lat + 1) begin
            failures++;
            $display("FAIL i_period g=%0d got %0d want %0d",
                     g, n - pen, lat + 1);
          end
        end
        pen = n;
      end
      if (i_rvalid[g]) begin
        er = (qr.size() > 0) ? qr.pop_front() : '1;
        nrv++;
        checks++;
        if ({word_idx[g], rdata[g]} !== er) begin
          failures++;
          $display("FAIL i_rdata g=%0d got %h want %h",
                   g, {word_idx[g], rdata[g]}, er);
        end
      end
      if (d_rvalid[g] || d_done[g]) seen_d = 1'b1;
      if (i_done[g]) begin
        nd = n;
        i_req[g] = 1'b0;
      end
    end
    i_req[g] = 1'b0;
    checks++;
    if (nd < 0 || n0 < 0 || nd - n0 != N * (lat + 1)) begin
      failures++;
      $display("FAIL i_done_time g=%0d got %0d want %0d",
               g, nd - n0, N * (lat + 1));
    end
    checks++;
    if (nrv != N || nen != N) begin
      failures++;
      $display("FAIL i_count g=%0d got rv=%0d en=%0d want %0d",
               g, nrv, nen, N);
    end
    checks++;
    if (seen_d) begin
      failures++;
      $display("FAIL i_d_side g=%0d got 1 want 0", g);
    end
    @(negedge clk);
    checks++;
    if ({i_done[g], busy[g]} !== 2'b00) begin
      failures++;
      $display("FAIL i_after g=%0d got %b want 00",
               g, {i_done[g], busy[g]});
    end
  endtask

  task automatic test_d_write();
    logic [31:0] qa[$];
    logic [34:0] qw[$];
    logic [31:0] ea;
    logic [34:0] ew;
    int n, nd, nrv, ndone;
    n = 0; nd = -1; nrv = 0; ndone = 0;
    for (int k = 0; k < N; k++) begin
      qa.push_back(32'h40 + 32'(4 * k));
      qw.push_back({3'(k), wdf(32'h40, 3'(k))});
    end
    @(negedge clk);
    d_req[0]  = 1'b1;
    d_we[0]   = 1'b1;
    d_addr[0] = 32'h40;
    while (nd < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_en[0]) begin
        ea = (qa.size() > 0) ? qa.pop_front() : 32'hFFFF_FFFF;
        ew = (qw.size() > 0) ? qw.pop_front() : '1;
        checks++;
        if ({mem_wr[0], mem_addr[0], word_idx[0], mem_wdata[0]}
            !== {1'b1, ea, ew}) begin
          failures++;
          $display("FAIL d_write got wr=%b a=%h i=%0d d=%h want a=%h %h",
                   mem_wr[0], mem_addr[0], word_idx[0], mem_wdata[0],
                   ea, ew);
        end
      end
      if (d_rvalid[0]) nrv++;
      if (d_done[0]) begin
        nd = n;
        ndone++;
        d_req[0] = 1'b0;
      end
    end
    d_req[0] = 1'b0;
    d_we[0]  = 1'b0;
    checks++;
    if (ndone != 1 || qa.size() != 0) begin
      failures++;
      $display("FAIL d_done got done=%0d left=%0d want 1 0",
               ndone, qa.size());
    end
    checks++;
    if (nrv != 0) begin
      failures++;
      $display("FAIL d_no_rvalid got %0d want 0", nrv);
    end
    @(negedge clk);
    checks++;
    if (d_done[0] !== 1'b0) begin
      failures++;
      $display("FAIL d_done_pulse got %b want 0", d_done[0]);
    end
  endtask

  task automatic test_tie();
    logic qo[$];
    logic eo;
    int n, last_done, ndone;
    bit pb;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      qo.push_back(OWN_D);
      qo.push_back(OWN_I);
      n = 0; last_done = -1; ndone = 0; pb = 1'b0;
      @(negedge clk);
      i_req[0]  = 1'b1;
      d_req[0]  = 1'b1;
      d_we[0]   = 1'b0;
      i_addr[0] = 32'h100;
      d_addr[0] = 32'h200;
      while (ndone < 2 && n < 200) begin
        @(negedge clk);
        n++;
        if (busy[0] && !pb) begin
          eo = (qo.size() > 0) ? qo.pop_front() : 1'bx;
          checks++;
          if (owner[0] !== eo) begin
            failures++;
            $display("FAIL tie_owner rep=%0d got %b want %b",
                     rep, owner[0], eo);
          end
          if (last_done >= 0) begin
            checks++;
            if (n != last_done + 2) begin
              failures++;
              $display("FAIL tie_regrant rep=%0d got %0d want %0d",
                       rep, n - last_done, 2);
            end
          end
        end
        pb = busy[0];
        if (d_done[0]) begin
          d_req[0] = 1'b0;
          last_done = n;
          ndone++;
        end
        if (i_done[0]) begin
          i_req[0] = 1'b0;
          last_done = n;
          ndone++;
        end
      end
      i_req[0] = 1'b0;
      d_req[0] = 1'b0;
      checks++;
      if (ndone != 2 || qo.size() != 0) begin
        failures++;
        $display("FAIL tie_done rep=%0d got %0d left=%0d want 2 0",
                 rep, ndone, qo.size());
      end
    end
  endtask

  task automatic test_d_during_i();
    logic qo[$];
    logic eo;
    int n, idone, nri, nrd;
    bit pb, raised, ddone;
    qo.push_back(OWN_I);
    qo.push_back(OWN_D);
    n = 0; idone = -1; nri = 0; nrd = 0;
    pb = 1'b0; raised = 1'b0; ddone = 1'b0;
    @(negedge clk);
    i_req[0]  = 1'b1;
    i_addr[0] = 32'h500;
    while (!ddone && n < 300) begin
      @(negedge clk);
      n++;
      if (busy[0] && !pb) begin
        eo = (qo.size() > 0) ? qo.pop_front() : 1'bx;
        checks++;
        if (owner[0] !== eo) begin
          failures++;
          $display("FAIL mid_owner got %b want %b", owner[0], eo);
        end
        if (idone >= 0) begin
          checks++;
          if (n != idone + 2 || mem_en[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_gap got %0d en=%b want 2 en=1",
                     n - idone, mem_en[0]);
          end
        end
      end
      pb = busy[0];
      if (mem_en[0] && mem_addr[0] == 32'h508 && !raised) begin
        raised    = 1'b1;
        d_req[0]  = 1'b1;
        d_we[0]   = 1'b0;
        d_addr[0] = 32'h600;
      end
      if (i_rvalid[0]) nri++;
      if (d_rvalid[0]) nrd++;
      if (i_done[0]) begin
        idone = n;
        i_req[0] = 1'b0;
      end
      if (d_done[0]) begin
        ddone = 1'b1;
        d_req[0] = 1'b0;
      end
    end
    d_req[0] = 1'b0;
    i_req[0] = 1'b0;
    checks++;
    if (!ddone || nri != N || nrd != N) begin
      failures++;
      $display("FAIL mid_counts got i=%0d d=%0d done=%b want %0d %0d 1",
               nri, nrd, ddone, N, N);
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    bit hit;
    n = 0; bad = 0; hit = 1'b0;
    @(negedge clk);
    i_req[0]  = 1'b1;
    i_addr[0] = 32'h300;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_en[0] && mem_addr[0] == 32'h30C) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rmid_reach got 0 want 1");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs(0) !== '0) begin
      failures++;
      $display("FAIL rmid_zero got %h want 0", outs(0));
    end
    i_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (i_done[0] || mem_en[0] || busy[0]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rmid_quiet got %0d want 0", bad);
    end
    test_i_refill(0, 32'h300);
  endtask

  task automatic test_latency();
    test_i_refill(1, 32'h0000_0ABC);
    test_i_refill(2, 32'h0000_7F00);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_i_refill(0, 32'h0000_1234);
    test_d_write();
    test_d_during_i();
    test_reset_mid();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
